spi_rx_frame: RTL and testbench

SPI slave-side receiver, directly downstream of the team's SPI master; consumes its SCL/SS/MOSI lines (CPOL 0, CPHA 1, MSB first).
Synchronises the pins into the clk domain and samples MOSI on each SCL falling edge while SS is low.
On SS deassertion, delivers each variable-length frame (e.g. 4-bit then 8-bit) as right-aligned data plus bit count over a valid/ready handshake.
Serves as the loopback checker and twin-side capture stage.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/sync_edge.sv | 33 +++
 rtl/spi_rx_frame.sv | 187 ++++++++++++++++++
 tb/tb_spi_rx_frame.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI slave-side frame receiver.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2
    } rx_state_t;

    // SPI mode 1: SCL idles low, data launched on rising edge, sampled on falling edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b1;

    localparam int unsigned DEFAULT_MAX_BITS = 16;

    // Smallest SCL half-period, in clk cycles, that the synchroniser can resolve.
    localparam int unsigned MIN_SCL_HALF_CLK = 3;

    localparam int unsigned LEN_W = 5;

endpackage

// File: rtl/sync_edge.sv
// N-flop synchroniser for one asynchronous pin, with registered rise/fall pulses.
module sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    assign level = chain[STAGES-1];

endmodule

// File: rtl/spi_rx_frame.sv
// SPI slave receiver: captures variable-length frames between SS edges and
// presents them right-aligned with a bit count over a valid/ready handshake.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_WAIT_IDLE | after reset; wait for synchroniser to settle and SS high
//   ST_IDLE      | SS high, waiting for SS falling edge; SCL ignored
//   ST_SHIFT     | SS low, sampling MOSI on each SCL sample edge
module spi_rx_frame
    import spi_pkg::*;
#(
    parameter int unsigned MAX_BITS    = DEFAULT_MAX_BITS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SCL,
    input  logic                SS,
    input  logic                MOSI,
    output logic [MAX_BITS-1:0] rx_data,
    output logic [LEN_W-1:0]    rx_len,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                rx_err_len,
    output logic                rx_overrun
);

    if (MAX_BITS < 1 || MAX_BITS > 31) begin : g_bad_max_bits
        $error("spi_rx_frame: MAX_BITS must be within 1..31");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("spi_rx_frame: SYNC_STAGES must be at least 2");
    end

    localparam logic [LEN_W-1:0] MAX_CNT       = LEN_W'(MAX_BITS);
    localparam int unsigned      SETTLE_CYCLES = SYNC_STAGES + MIN_SCL_HALF_CLK - 1;
    localparam logic [7:0]       SETTLE_INIT   = 8'(SETTLE_CYCLES);

    logic scl_level, scl_rise, scl_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_scl (
        .clk   (clk),
        .rst   (rst),
        .d     (SCL),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk   (clk),
        .rst   (rst),
        .d     (SS),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst   (rst),
        .d     (MOSI),
        .level (mosi_level),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    // Trailing edge is the sample edge when CPHA=1; its direction follows CPOL.
    logic scl_sample;
    assign scl_sample = (CPOL ^ CPHA) ? scl_fall : scl_rise;

    rx_state_t          state, state_next;
    logic [MAX_BITS-1:0] shift_reg;
    logic [LEN_W-1:0]    count;
    logic                ovf;
    logic [7:0]          settle;

    logic handshake;
    logic do_clear, do_shift, do_sat, do_load, do_drop;

    assign handshake = rx_valid & rx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_WAIT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_shift   = 1'b0;
        do_sat     = 1'b0;
        do_load    = 1'b0;
        do_drop    = 1'b0;
        case (state)
            ST_WAIT_IDLE: begin
                if (settle == 8'd0 && ss_level) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (ss_fall) begin
                    do_clear   = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Frame end takes priority over a coincident sample edge.
                if (ss_rise) begin
                    state_next = ST_IDLE;
                    if (count != '0) begin
                        if (!rx_valid || handshake) begin
                            do_load = 1'b1;
                        end else begin
                            do_drop = 1'b1;
                        end
                    end
                end else if (scl_sample) begin
                    if (count < MAX_CNT) begin
                        do_shift = 1'b1;
                    end else begin
                        do_sat = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_WAIT_IDLE;
            end
        endcase
    end

    // Holds off WAIT_IDLE exit until the synchronisers reflect the real pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle <= SETTLE_INIT;
        end else if (settle != 8'd0) begin
            settle <= settle - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            count     <= '0;
            ovf       <= 1'b0;
        end else if (do_clear) begin
            shift_reg <= '0;
            count     <= '0;
            ovf       <= 1'b0;
        end else if (do_shift) begin
            shift_reg <= (shift_reg << 1) | MAX_BITS'(mosi_level);
            count     <= count + LEN_W'(1);
        end else if (do_sat) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_len     <= '0;
            rx_err_len <= 1'b0;
            rx_valid   <= 1'b0;
        end else if (do_load) begin
            rx_data    <= shift_reg;
            rx_len     <= count;
            rx_err_len <= ovf;
            rx_valid   <= 1'b1;
        end else if (handshake) begin
            rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_overrun <= 1'b0;
        end else if (do_drop) begin
            rx_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_rx_frame.sv
// Scoreboard bench for spi_rx_frame: frames are driven on the SPI pins and the
// expected result queued; the monitor pops and compares on every handshake.
module tb_spi_rx_frame;

    localparam int MAX_BITS    = 16;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 10;

    typedef struct {
        logic [MAX_BITS-1:0] data;
        logic [4:0]          len;
        logic                err;
    } frame_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                SCL, SS, MOSI;
    logic [MAX_BITS-1:0] rx_data;
    logic [4:0]          rx_len;
    logic                rx_valid;
    logic                rx_ready;
    logic                rx_err_len;
    logic                rx_overrun;

    frame_t sb[$];
    int     n_vec  = 0;
    int     n_miss = 0;
    int     valid_cycles = 0;

    spi_rx_frame #(.MAX_BITS(MAX_BITS), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk        (clk),
        .rst        (rst),
        .SCL        (SCL),
        .SS         (SS),
        .MOSI       (MOSI),
        .rx_data    (rx_data),
        .rx_len     (rx_len),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_err_len (rx_err_len),
        .rx_overrun (rx_overrun)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame", rx_valid, 0);
                end else begin
                    frame_t f;
                    f = sb.pop_front();
                    check("rx_data", rx_data, f.data);
                    check("rx_len", rx_len, f.len);
                    check("rx_err_len", rx_err_len, f.err);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            SCL  = 1'b1;
            MOSI = v[i];
            tick(HALF);
            SCL = 1'b0;
            tick(HALF);
        end
    endtask

    task automatic send_frame(input logic [31:0] v, input int n);
        tick(HALF);
        SS = 1'b0;
        tick(HALF);
        send_bits(v, n);
        SS = 1'b1;
    endtask

    task automatic push(input logic [MAX_BITS-1:0] d, input logic [4:0] l, input logic e);
        frame_t f;
        f.data = d;
        f.len  = l;
        f.err  = e;
        sb.push_back(f);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rx_valid) return;
        end
        check("valid_timeout", rx_valid, 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        tick(1);
        rx_ready = 1'b1;
        while (sb.size() != 0 && k < 50) begin
            tick(1);
            k++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        int lat;
        int v0;
        rst = 1'b0; SCL = 1'b0; SS = 1'b1; MOSI = 1'b0; rx_ready = 1'b0;
        tick(3);
        @(negedge clk);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_len", rx_len, 0);
        check("reset_err", rx_err_len, 0);
        check("reset_overrun", rx_overrun, 0);
        tick(1);
        rst = 1'b1;
        tick(10);

        // 4-bit frame, held until accepted; latency from SS rise
        push(16'h000F, 5'd4, 1'b0);
        send_frame(32'hF, 4);
        wait_valid(lat);
        check("latency_in_window", (lat >= SYNC_STAGES + 2 && lat <= SYNC_STAGES + 3), 1);
        tick(5);
        check("hold_valid", rx_valid, 1);
        drain();

        // 8-bit frame with ready already high: single-cycle valid
        push(16'h0038, 5'd8, 1'b0);
        send_frame(32'h38, 8);
        wait_valid(lat);
        @(posedge clk);
        @(negedge clk);
        check("valid_pulse", rx_valid, 0);

        // Second frame arrives while first is unaccepted: dropped, overrun sticky
        tick(1);
        rx_ready = 1'b0;
        push(16'h00A5, 5'd8, 1'b0);
        send_frame(32'hA5, 8);
        wait_valid(lat);
        send_frame(32'h3C, 8);
        tick(10);
        check("held_data", rx_data, 16'h00A5);
        check("overrun_set", rx_overrun, 1);
        drain();
        tick(30);
        check("no_second_frame", rx_valid, 0);

        // Over-long frame: first MAX_BITS kept, error flagged
        push(16'hFFFF, 5'd16, 1'b1);
        send_frame(32'h000FFFF0, 20);
        wait_valid(lat);
        tick(5);
        check("overrun_sticky", rx_overrun, 1);

        // SCL noise with SS high, then empty SS pulse
        v0 = valid_cycles;
        tick(HALF);
        for (int i = 0; i < 10; i++) begin
            SCL = 1'b1; tick(HALF);
            SCL = 1'b0; tick(HALF);
        end
        SS = 1'b0; tick(HALF);
        SS = 1'b1; tick(30);
        check("idle_noise_no_valid", valid_cycles - v0, 0);

        // Reset in the middle of a frame: partial frame never delivered
        v0 = valid_cycles;
        SS = 1'b0;
        tick(HALF);
        send_bits(32'h5, 3);
        rst = 1'b0;
        tick(1);
        @(negedge clk);
        check("midreset_overrun", rx_overrun, 0);
        check("midreset_valid", rx_valid, 0);
        tick(2);
        rst = 1'b1;
        send_bits(32'h1A, 5);
        SS = 1'b1;
        tick(30);
        check("partial_no_valid", valid_cycles - v0, 0);

        push(16'h005A, 5'd8, 1'b0);
        send_frame(32'h5A, 8);
        wait_valid(lat);
        tick(5);
        check("final_queue_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
